// File: rtl/softermax_pkg.sv
// Shared types and helpers for the Softermax normalizer: FSM states, the
// 2^(f/4) fractional LUT and the saturating integer ceiling of a Q.2 logit.
package softermax_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam int LUT_W = 13;

    localparam logic [LUT_W-1:0] POW2_LUT_0 = 13'd4096;
    localparam logic [LUT_W-1:0] POW2_LUT_1 = 13'd4871;
    localparam logic [LUT_W-1:0] POW2_LUT_2 = 13'd5793;
    localparam logic [LUT_W-1:0] POW2_LUT_3 = 13'd6889;

    function automatic logic [LUT_W-1:0] pow2_lut(input logic [1:0] f);
        logic [LUT_W-1:0] v;
        case (f)
            2'd0:    v = POW2_LUT_0;
            2'd1:    v = POW2_LUT_1;
            2'd2:    v = POW2_LUT_2;
            2'd3:    v = POW2_LUT_3;
            default: v = POW2_LUT_0;
        endcase
        return v;
    endfunction

    // Ceiling of a sign-extended Q.2 value; clamps to the largest integer of a bw-bit logit.
    function automatic logic signed [15:0] ceil_q2(input logic signed [15:0] x, input int bw);
        logic signed [15:0] y;
        logic signed [15:0] lim;
        lim = 16'((32'sd1 <<< (bw - 1)) - 32'sd4);
        if (x[1:0] != 2'b00) begin
            y = $signed({x[15:2], 2'b00}) + 16'sd4;
        end else begin
            y = x;
        end
        if (y > lim) begin
            y = lim;
        end else begin
            y = y;
        end
        return y;
    endfunction

endpackage

// File: rtl/softermax_norm_accum_pow2_term.sv
// Combinational 2^d term in Q.12 for a non-positive Q.2 difference d:
// LUT of the fractional quarter, right-shifted by the integer magnitude.
module pow2_term
    import softermax_pkg::*;
#(
    parameter int BW = 8,
    parameter int SW = 16
) (
    input  logic [BW:0]   i_d,
    output logic [SW-1:0] o_term
);

    logic             w_neg;
    logic [1:0]       w_f;
    logic [BW-2:0]    w_nshift;
    logic [LUT_W-1:0] w_lut;

    assign w_neg    = i_d[BW];
    assign w_f      = i_d[1:0];
    assign w_nshift = (~i_d[BW:2]) + (BW-1)'(1);
    assign w_lut    = pow2_lut(w_f);

    // Floor split: the integer part is i_d[BW:2]; a negative one becomes a right shift.
    always_comb begin
        o_term = {SW{1'b0}};
        if (!w_neg) begin
            o_term = SW'(w_lut);
        end else if (32'(w_nshift) >= SW) begin
            o_term = {SW{1'b0}};
        end else begin
            o_term = SW'(w_lut) >> w_nshift;
        end
    end

endmodule

// File: rtl/softermax_norm_accum.sv
// Streaming Softermax stage: running integer max and renormalized denominator
// sum over VEC_SIZE logits, result held until the downstream handshake.
module softermax_norm_accum
    import softermax_pkg::*;
#(
    parameter int BW       = 8,
    parameter int FW       = 2,
    parameter int VEC_SIZE = 5,
    parameter int SW       = 16,
    parameter int SFW      = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [BW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [BW-1:0] max_out,
    output logic [SW-1:0] sum_out
);

    localparam int CW = (VEC_SIZE > 1) ? $clog2(VEC_SIZE) : 1;

    if (FW != 2 || SFW != 12) begin : g_bad_format
        $error("softermax_norm_accum supports only FW = 2 with SFW = 12");
    end

    state_e        r_state;
    state_e        w_next_state;
    logic [CW-1:0] r_cnt;
    logic [BW-1:0] r_m;
    logic [SW-1:0] r_s;
    logic          r_in_ready;
    logic          r_out_valid;

    logic              w_accept;
    logic              w_first;
    logic              w_last;
    logic signed [15:0] w_c_wide;
    logic [BW-1:0]     w_c;
    logic              w_c_gt;
    logic [BW-1:0]     w_m_new;
    logic [BW:0]       w_m_diff;
    logic [BW-2:0]     w_shamt;
    logic [BW:0]       w_d;
    logic [SW-1:0]     w_term;
    logic [SW-1:0]     w_s_base;
    logic [SW:0]       w_sum_wide;
    logic [SW-1:0]     w_s_new;
    logic              w_unused;

    assign w_accept = in_valid && r_in_ready;
    assign w_first  = (r_state == ST_IDLE);
    assign w_last   = (r_cnt == CW'(VEC_SIZE - 1));

    assign w_c_wide = ceil_q2(16'($signed(in_data)), BW);
    assign w_c      = w_c_wide[BW-1:0];
    assign w_c_gt   = $signed(w_c) > $signed(r_m);
    assign w_m_new  = (w_first || w_c_gt) ? w_c : r_m;

    // Both maxima are integers, so the difference divided by 4 is the renormalizing shift.
    assign w_m_diff = {w_m_new[BW-1], w_m_new} - {r_m[BW-1], r_m};
    assign w_shamt  = w_m_diff[BW:2];
    assign w_d      = {in_data[BW-1], in_data} - {w_m_new[BW-1], w_m_new};
    assign w_unused = ^{w_c_wide[15:BW], w_m_diff[1:0]};

    pow2_term #(
        .BW (BW),
        .SW (SW)
    ) u_pow2_term (
        .i_d    (w_d),
        .o_term (w_term)
    );

    // Previous sum rescaled to the new max; a fresh vector starts from zero.
    always_comb begin
        w_s_base = {SW{1'b0}};
        if (w_first) begin
            w_s_base = {SW{1'b0}};
        end else if (32'(w_shamt) >= SW) begin
            w_s_base = {SW{1'b0}};
        end else begin
            w_s_base = r_s >> w_shamt;
        end
    end

    assign w_sum_wide = {1'b0, w_s_base} + {1'b0, w_term};
    assign w_s_new    = w_sum_wide[SW] ? {SW{1'b1}} : w_sum_wide[SW-1:0];

    // Next-state logic for the vector FSM.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = w_last ? ST_DONE : ST_ACCUM;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (w_accept && w_last) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_ACCUM;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_DONE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // State, handshake flags and the M/S accumulators.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= {CW{1'b0}};
            r_m         <= {BW{1'b0}};
            r_s         <= {SW{1'b0}};
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_in_ready  <= (w_next_state != ST_DONE);
            r_out_valid <= (w_next_state == ST_DONE);
            if (w_accept) begin
                r_m   <= w_m_new;
                r_s   <= w_s_new;
                r_cnt <= w_last ? {CW{1'b0}} : r_cnt + CW'(1);
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign max_out   = r_m;
    assign sum_out   = r_s;

endmodule

// File: tb/tb_softermax_norm_accum.sv
// Self-checking bench for softermax_norm_accum: directed vectors from the
// test plan plus randomized vectors checked against an arithmetic model.
module tb_softermax_norm_accum;

    localparam int BW  = 8;
    localparam int SW  = 16;
    localparam int VEC = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [BW-1:0] in_data = 8'h00;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [BW-1:0] max_out;
    logic [SW-1:0] sum_out;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    softermax_norm_accum #(
        .BW (BW), .FW (2), .VEC_SIZE (VEC), .SW (SW), .SFW (12)
    ) dut (
        .clk (clk), .rst (rst),
        .in_valid (in_valid), .in_ready (in_ready), .in_data (in_data),
        .out_valid (out_valid), .out_ready (out_ready),
        .max_out (max_out), .sum_out (sum_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int ref_ceil(input int x);
        int q;
        q = x >>> 2;
        if ((x & 3) != 0) q = q + 1;
        if (q * 4 > 124) return 124;
        return q * 4;
    endfunction

    function automatic longint ref_term(input int d);
        int i;
        int f;
        longint lut;
        i = d >>> 2;
        f = d & 3;
        case (f)
            0: lut = 4096;
            1: lut = 4871;
            2: lut = 5793;
            default: lut = 6889;
        endcase
        if (i >= 0) return lut;
        if (-i >= 63) return 0;
        return lut >> (-i);
    endfunction

    task automatic ref_vector(input int xs[VEC], output int m, output longint s);
        int cx;
        int nm;
        int sh;
        m = 0;
        s = 0;
        for (int k = 0; k < VEC; k++) begin
            cx = ref_ceil(xs[k]);
            if (k == 0) begin
                m = cx;
                s = ref_term(xs[k] - m);
            end else begin
                nm = (cx > m) ? cx : m;
                sh = (nm - m) / 4;
                s  = (sh >= SW) ? 0 : (s >> sh);
                s  = s + ref_term(xs[k] - nm);
                if (s > 65535) s = 65535;
                m = nm;
            end
        end
    endtask

    task automatic push(input int v);
        int guard;
        guard = 0;
        in_valid = 1'b1;
        in_data  = v[7:0];
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL push_timeout: in_ready=%0b required 1", in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_vector(input int xs[VEC], input string tag, input int exp_m,
                              input longint exp_s, input int hold, input bit tp_check);
        int t0;
        int rnd;
        logic [BW-1:0] em;
        logic [SW-1:0] es;
        em = exp_m[7:0];
        es = exp_s[15:0];
        t0 = cyc;
        for (int k = 0; k < VEC; k++) begin
            push(xs[k]);
            if (k == VEC - 2) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL %s early_valid: out_valid=%0b required 0", tag, out_valid);
                end
            end
        end
        in_valid = 1'b0;
        if (tp_check) begin
            checks++;
            if (cyc - t0 != VEC) begin
                errors++;
                $display("FAIL %s throughput: cycles=%0d required %0d", tag, cyc - t0, VEC);
            end
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || max_out !== em || sum_out !== es) begin
            errors++;
            $display("FAIL %s result: valid=%0b ready=%0b max=%h sum=%0d required 1 0 %h %0d",
                     tag, out_valid, in_ready, max_out, sum_out, em, es);
        end
        for (int h = 0; h < hold; h++) begin
            rnd = $urandom_range(0, 255);
            in_valid = 1'b1;
            in_data  = rnd[7:0];
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || max_out !== em || sum_out !== es) begin
                errors++;
                $display("FAIL %s hold%0d: valid=%0b ready=%0b max=%h sum=%0d required 1 0 %h %0d",
                         tag, h, out_valid, in_ready, max_out, sum_out, em, es);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s after_handshake: valid=%0b ready=%0b required 0 1",
                     tag, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #3;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || max_out !== 8'h00 || sum_out !== 16'h0000) begin
            errors++;
            $display("FAIL reset_state: ready=%0b valid=%0b max=%h sum=%h required 0 0 00 0000",
                     in_ready, out_valid, max_out, sum_out);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ready=%0b valid=%0b required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_directed();
        int v[VEC];
        v = '{0, 0, 0, 0, 0};
        run_vector(v, "zeros", 8'h00, 20480, 0, 1'b1);
        v = '{4, 0, 0, 0, 0};
        run_vector(v, "one_hot", 8'h04, 12288, 0, 1'b1);
        v = '{0, 0, 8, 8, 8};
        run_vector(v, "renorm", 8'h08, 14336, 0, 1'b1);
        v = '{-128, 127, -128, -128, -128};
        run_vector(v, "extremes", 8'h7C, 6889, 0, 1'b1);
    endtask

    task automatic test_back_to_back();
        int v[VEC];
        v = '{4, 0, 0, 0, 0};
        run_vector(v, "backpressure", 8'h04, 12288, 3, 1'b1);
        v = '{0, 0, 0, 0, 0};
        run_vector(v, "after_bp", 8'h00, 20480, 0, 1'b1);
    endtask

    task automatic test_reset_mid_vector();
        int v[VEC];
        push(12);
        push(-40);
        in_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || max_out !== 8'h00 || sum_out !== 16'h0000) begin
            errors++;
            $display("FAIL mid_reset: ready=%0b valid=%0b max=%h sum=%h required 0 0 00 0000",
                     in_ready, out_valid, max_out, sum_out);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        v = '{0, 0, 0, 0, 0};
        run_vector(v, "post_reset", 8'h00, 20480, 0, 1'b1);
    endtask

    task automatic test_random();
        int v[VEC];
        int r;
        int m;
        longint s;
        for (int n = 0; n < 40; n++) begin
            for (int k = 0; k < VEC; k++) begin
                r = $urandom_range(0, 9);
                if (r == 0) v[k] = 127;
                else if (r == 1) v[k] = -128;
                else if (r == 2) v[k] = $urandom_range(120, 127);
                else begin
                    v[k] = $urandom_range(0, 255);
                    v[k] = v[k] - 128;
                end
            end
            ref_vector(v, m, s);
            run_vector(v, $sformatf("rand%0d", n), m, s, $urandom_range(0, 2), 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid_vector();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/softermax_norm_accum.md
# softermax_norm_accum

Streaming Softermax normalizer and denominator accumulator. It is the consumer side of the integer-max stage: it accepts one fixed-point logit per cycle and keeps a running integer (ceiling) max. It also keeps the running denominator sum of 2^(x − max), renormalizing the sum by a right shift whenever the max rises. After VEC_SIZE elements it presents the final integer max and the denominator to the downstream reciprocal/normalize stage.

## Interface
- BW, 8, logit width, signed two's complement
- FW, 2, logit fractional bits; only FW = 2 is supported, any other value is an elaboration error
- VEC_SIZE, 5, elements per vector
- SW, 16, denominator sum width, unsigned
- SFW, 12, denominator fractional bits
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  logit valid
- in_ready  out  1  block can accept a logit
- in_data  in  BW  logit, signed QBW-FW.FW
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- max_out  out  BW  final integer max, same format as in_data, fractional bits 0
- sum_out  out  SW  denominator, unsigned Q(SW-SFW).SFW, saturating

## Operation
- States:
  - IDLE: no element of the current vector has been accepted yet.
  - ACCUM: 1 to VEC_SIZE−1 elements accepted.
  - DONE: result held on the outputs.
- Accept rule: a logit is accepted on a cycle with in_valid && in_ready.
- in_ready is 1 in IDLE and ACCUM, and 0 in DONE.
- Ceiling, c(x):
  - If the fractional bits are nonzero, clear them and add 1.0; otherwise x is unchanged.
  - Saturate to the largest integer, {0,1…1,00} (0x7C for BW = 8), on overflow.
- First element of a vector: M := c(x); S := term(x − M).
- Later elements:
  - M' = max(M, c(x)), compared signed.
  - S := sat(S >> (M' − M) + term(x − M')); then M := M'.
  - A shift of SW or more yields 0.
- term(d):
  - d is computed in BW+1 signed bits.
  - Split d = i + f/4, with i = floor(d) and f in 0..3.
  - term = LUT[f] >> (−i) when i < 0; term = LUT[f] when i ≥ 0.
  - i can be ≥ 0 only in the saturated-ceiling case, and is then at most 0.
- LUT in Q.SFW, i.e. 2^(f/4) × 4096: 4096, 4871, 5793, 6889.
- Saturation: sat(...) clamps the sum to 2^SW − 1.
- Element counter: 0..VEC_SIZE−1. Acceptance of the element at count VEC_SIZE−1 moves the FSM to DONE and clears the counter.
- DONE:
  - max_out = M and sum_out = S, held stable while out_valid && !out_ready.
  - The out handshake returns the FSM to IDLE.
  - in_ready stays 0 in the handshake cycle, so there is no overlap between vectors.
- Reset mid-vector: all state is cleared and the partial vector is discarded. The next accepted logit is treated as element 0.

## Timing
- Reset values: in_ready 0 while rst is asserted and 1 after release (IDLE); out_valid 0; max_out 0; sum_out 0; counter 0; FSM IDLE.
- Throughput: one logit per cycle, no bubbles while in_valid is held.
- M and S update registered on the accepting edge. The max compare, shift, LUT lookup and add all fit in a single combinational cycle.
- Latency: out_valid rises on the edge that accepts the last element, so it is visible in the following cycle.
- Back-to-back vectors: the minimum period is VEC_SIZE + 1 cycles, because the DONE cycle is required.
- out_valid drops on the edge after the out handshake.

## Structure
- Package softermax_pkg holds:
  - the pow2 fractional LUT constants (4096, 4871, 5793, 6889);
  - the FSM state enum (IDLE, ACCUM, DONE);
  - the ceiling function, saturating identically to the max stage.
- Sub-module pow2_term:
  - Combinational: input d (BW+1 bits signed) → output term (SW bits).
  - Contains the LUT and the right shift; shift amounts ≥ SW yield 0.
- The top level contains the FSM, counter, M/S registers and output holding.

## Test plan
All tests use the default parameters.
- Five logits of 0x00 → max_out 0x00, sum_out 20480 (0x5000); out_valid in the cycle after the 5th accept.
- [0x04, 0x00, 0x00, 0x00, 0x00] → max_out 0x04, sum_out 4096 + 4 × 2048 = 12288.
- Renormalization, [0x00, 0x00, 0x08, 0x08, 0x08] → after element 2, S = 8192 >> 2 + 4096 = 6144; final max_out 0x08, sum_out 14336.
- Extremes, [0x80, 0x7F, 0x80, 0x80, 0x80]:
  - Ceiling saturates to 0x7C and the shift of 63 zeroes S.
  - term(0.75) = 6889; the remaining terms are 0.
  - Result: max_out 0x7C, sum_out 6889.
- Backpressure: hold out_ready = 0 for 3 cycles with in_valid = 1 → outputs stable, in_ready = 0, no input consumed; the next vector starts the cycle after the handshake.
- Reset after 2 accepts → all outputs 0 and FSM IDLE; then five 0x00 logits → sum_out 20480, with no contribution from the aborted vector.
